// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 16-bit register-file/ALU datapath and its controller.
package cpu_pkg;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned IR_W    = OPC_W + OP_W;
    localparam int unsigned NSEL_W  = 3;
    localparam int unsigned VSEL_W  = 2;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WRIMM  = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_ALU    = 3'd5,
        S_WRREG  = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

    localparam logic [OP_W-1:0] OP_MOVIMM = 2'b10;
    localparam logic [OP_W-1:0] OP_MOVREG = 2'b00;
    localparam logic [OP_W-1:0] OP_ADD    = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP    = 2'b01;
    localparam logic [OP_W-1:0] OP_AND    = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN    = 2'b11;

    localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
    localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
    localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
    localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

    localparam logic [VSEL_W-1:0] VSEL_C   = 2'b00;
    localparam logic [VSEL_W-1:0] VSEL_IMM = 2'b10;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 2'b11;

    typedef struct packed {
        logic is_movimm;
        logic is_movreg;
        logic is_mvn;
        logic is_cmp;
        logic is_alu3;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps the latched {opcode,op} to one-hot instruction class flags.
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [IR_W-1:0] ir_i,
    output instr_class_t    cls_c
);

    logic [OPC_W-1:0] opc;
    logic [OP_W-1:0]  op;

    assign opc = ir_i[IR_W-1:OP_W];
    assign op  = ir_i[OP_W-1:0];

    always_comb begin
        cls_c           = '0;
        cls_c.is_movimm = (opc == OPC_MOV) && (op == OP_MOVIMM);
        cls_c.is_movreg = (opc == OPC_MOV) && (op == OP_MOVREG);
        cls_c.is_mvn    = (opc == OPC_ALU) && (op == OP_MVN);
        cls_c.is_cmp    = (opc == OPC_ALU) && (op == OP_CMP);
        cls_c.is_alu3   = (opc == OPC_ALU) && ((op == OP_ADD) || (op == OP_AND));
        cls_c.illegal   = !(cls_c.is_movimm || cls_c.is_movreg || cls_c.is_mvn
                            || cls_c.is_cmp || cls_c.is_alu3);
    end

endmodule

// File: rtl/cpu_controller.sv
// Moore controller sequencing the register-file/ALU datapath one instruction at a time.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [OP_W-1:0]      op,
    output logic                 w,
    output logic [NSEL_W-1:0]    nsel,
    output logic [VSEL_W-1:0]    vsel,
    output logic                 write,
    output logic                 loada,
    output logic                 loadb,
    output logic                 loadc,
    output logic                 loads,
    output logic                 asel,
    output logic [ALUOP_W-1:0]   ALUop
);

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    instr_class_t        cls;

    logic                w_q, w_d;
    logic [NSEL_W-1:0]   nsel_q, nsel_d;
    logic [VSEL_W-1:0]   vsel_q, vsel_d;
    logic                write_q, write_d;
    logic                loada_q, loada_d;
    logic                loadb_q, loadb_d;
    logic                loadc_q, loadc_d;
    logic                loads_q, loads_d;
    logic                asel_q, asel_d;
    logic [ALUOP_W-1:0]  aluop_q, aluop_d;

    instr_class_decode u_decode (
        .ir_i  (ir_q),
        .cls_c (cls)
    );

    // Next state, then outputs decoded from the next state so they register in step with it.
    // ir_q is stable outside WAIT, so its class flags are valid for every state that uses them.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        w_d     = 1'b0;
        nsel_d  = NSEL_NONE;
        vsel_d  = VSEL_C;
        write_d = 1'b0;
        loada_d = 1'b0;
        loadb_d = 1'b0;
        loadc_d = 1'b0;
        loads_d = 1'b0;
        asel_d  = 1'b0;
        aluop_d = ALU_ADD;

        case (state_q)
            S_WAIT: begin
                if (s) begin
                    ir_d    = {opcode, op};
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls.illegal)                       state_d = S_WAIT;
                else if (cls.is_movimm)                state_d = S_WRIMM;
                else if (cls.is_movreg || cls.is_mvn)  state_d = S_GETB;
                else if (cls.is_cmp || cls.is_alu3)    state_d = S_GETA;
                else                                   state_d = S_WAIT;
            end
            S_WRIMM: state_d = S_WAIT;
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_ALU;
            S_ALU:   state_d = cls.is_cmp ? S_WAIT : S_WRREG;
            S_WRREG: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase

        case (state_d)
            S_WAIT: w_d = 1'b1;
            S_WRIMM: begin
                nsel_d  = NSEL_RN;
                vsel_d  = VSEL_IMM;
                write_d = 1'b1;
            end
            S_GETA: begin
                nsel_d  = NSEL_RN;
                loada_d = 1'b1;
            end
            S_GETB: begin
                nsel_d  = NSEL_RM;
                loadb_d = 1'b1;
            end
            S_ALU: begin
                loadc_d = !cls.is_cmp;
                loads_d = cls.is_cmp;
                if (cls.is_movreg) begin
                    asel_d  = 1'b1;
                    aluop_d = ALU_ADD;
                end else if (cls.is_mvn) begin
                    asel_d  = 1'b1;
                    aluop_d = ALU_NOT;
                end else begin
                    aluop_d = ir_q[OP_W-1:0];
                end
            end
            S_WRREG: begin
                nsel_d  = NSEL_RD;
                vsel_d  = VSEL_C;
                write_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            w_q     <= 1'b1;
            nsel_q  <= NSEL_NONE;
            vsel_q  <= VSEL_C;
            write_q <= 1'b0;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            asel_q  <= 1'b0;
            aluop_q <= ALU_ADD;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            w_q     <= w_d;
            nsel_q  <= nsel_d;
            vsel_q  <= vsel_d;
            write_q <= write_d;
            loada_q <= loada_d;
            loadb_q <= loadb_d;
            loadc_q <= loadc_d;
            loads_q <= loads_d;
            asel_q  <= asel_d;
            aluop_q <= aluop_d;
        end
    end

    assign w     = w_q;
    assign nsel  = nsel_q;
    assign vsel  = vsel_q;
    assign write = write_q;
    assign loada = loada_q;
    assign loadb = loadb_q;
    assign loadc = loadc_q;
    assign loads = loads_q;
    assign asel  = asel_q;
    assign ALUop = aluop_q;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Moore state machine that sequences the 16-bit register-file/ALU datapath one instruction at a time. It decodes the latched instruction class and drives register-file selects, pipeline-register load enables, operand muxes and the 2-bit ALU operation code. It sits between the instruction register and the datapath, with a start/wait handshake to the top level. The ALU itself and its status flags `Z[2:0]` are outside this block; this block only decides when status is captured.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s` in 1: start; sampled only in WAIT.
- `opcode` in 3: instruction bits [15:13].
- `op` in 2: instruction bits [12:11].
- `w` out 1: 1 = idle, ready for `s`.
- `nsel` out 3: register-file read/write select, one-hot: 001 = Rn, 010 = Rd, 100 = Rm, 000 = none.
- `vsel` out 2: write-back source: 00 = C register, 10 = sign-extended imm8.
- `write` out 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: A, B, C and status register enables.
- `asel` out 1: 1 forces ALU A input to 16'h0000.
- `ALUop` out 2: 00 ADD, 01 SUB, 10 AND, 11 NOT B.

## Operation
- Supported instructions `{opcode,op}`: 110_10 MOV Rn,#imm8; 110_00 MOV Rd,Rm; 101_00 ADD; 101_01 CMP; 101_10 AND; 101_11 MVN. All other codes are illegal.
- `{opcode,op}` is latched into internal `ir_q` on the WAIT→DECODE edge. Later changes on the inputs have no effect until the next WAIT.
- States and their actions. Any output not listed is 0. `nsel` defaults to 000, `vsel` to 00 and `ALUop` to 00.
  - WAIT: `w`=1. Goes to DECODE when `s`=1, otherwise stays in WAIT.
  - DECODE: no actions.
    - 110_10 goes to WRIMM.
    - 110_00 and 101_11 go to GETB.
    - 101_00, 101_01 and 101_10 go to GETA.
    - Illegal codes go to WAIT with no writes.
  - WRIMM: `nsel`=001, `vsel`=10, `write`=1. Goes to WAIT.
  - GETA: `nsel`=001, `loada`=1. Goes to GETB.
  - GETB: `nsel`=100, `loadb`=1. Goes to ALU.
  - ALU: `loadc`=1.
    - MOV: `asel`=1, `ALUop`=00.
    - MVN: `asel`=1, `ALUop`=11.
    - 101 class other than MVN: `ALUop`=`op`.
    - CMP: `loadc`=0, `loads`=1. The status register is loaded only by CMP.
    - CMP goes to WAIT; all others go to WRREG.
  - WRREG: `nsel`=010, `vsel`=00, `write`=1. Goes to WAIT.
- At most one of `write`/`loada`/`loadb`/`loadc`/`loads` is high in any state.

## Timing
- Reset: state forced to WAIT asynchronously; `ir_q`=00000.
  - Outputs during and after reset: `w`=1, all others 0.
  - Reset mid-instruction abandons it; no write is issued after `reset_n` falls.
- All outputs are a pure decode of state and `ir_q` (registered state, no input-to-output paths).
- `s` is ignored outside WAIT. If `s` is held high, the next instruction starts on the edge after returning to WAIT, so `w` is high for exactly one cycle.
- Edges from the `s`-sampling edge to `w` returning high:
  - MOV imm: 3.
  - MOV reg / MVN: 5.
  - CMP: 5.
  - ADD / AND: 6.
  - Illegal: 2.
- The register-file write commits on the edge that leaves WRIMM/WRREG. A,B,C,S capture on the edge that leaves the state asserting their load.

## Structure
- Shared package `cpu_pkg`:
  - state enum (WAIT, DECODE, WRIMM, GETA, GETB, ALU, WRREG; 3-bit binary encoding);
  - opcode/op constants;
  - `NSEL_RN`/`NSEL_RD`/`NSEL_RM`;
  - `VSEL_C`/`VSEL_IMM`;
  - `ALU_ADD`/`ALU_SUB`/`ALU_AND`/`ALU_NOT`.
  The same package is used by the datapath top.
- One sub-module, `instr_class_decode`: combinational, mapping `ir_q` to class flags (is_movimm, is_movreg, is_mvn, is_cmp, is_alu3, illegal). The FSM itself stays in `cpu_controller`.

## Test plan
- Reset: assert `reset_n`=0 mid-GETB of an ADD → `w`=1 and all enables 0 within the same cycle; release, then one cycle with `s`=0 → still WAIT.
- MOV imm: `opcode`=110, `op`=10, pulse `s`.
  - Cycle 2: `nsel`=001, `vsel`=10, `write`=1.
  - `w`=1 after the 3rd edge.
- ADD: `opcode`=101, `op`=00.
  - Sequence: `loada`(`nsel`=001), `loadb`(`nsel`=100), `loadc` with `ALUop`=00 `asel`=0, then `write` with `nsel`=010 `vsel`=00.
  - `w`=1 after 6 edges.
- CMP: `opcode`=101, `op`=01 → ALU state has `ALUop`=01, `loads`=1, `loadc`=0; never `write`; `w`=1 after 5 edges.
- MVN and MOV reg:
  - MVN (101_11) → no `loada`; ALU state `asel`=1, `ALUop`=11.
  - MOV reg (110_00) → ALU state `asel`=1, `ALUop`=00.
  - Both write Rd.
- Latching and illegal code: change `opcode` to 111 during GETA of an AND → the AND completes unchanged. Then start with 111_00 → back in WAIT after 2 edges with no enable ever high.
